// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-stage controller: FSM states, access size codes, default timeout.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } stateT;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Size 11 has no legal encoding, so it is treated as always misaligned.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addrLo[0];
      SZ_WORD: bad = (addrLo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian lane select plus sign/zero extension of a RAM read word; purely combinational.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] data
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    byteLane = rdata[{addr, 3'b000} +: 8];
    halfLane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = {{24{isSigned & byteLane[7]}}, byteLane};
      SZ_HALF: data = {{16{isSigned & halfLane[15]}}, halfLane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Load/store controller between the CPU memory stage and a RAM with a completion handshake.
// Minimum 4 cycles per access (request, issue, wait, done); the CPU is stalled until completion or timeout.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        ram_en,
  output logic        ram_mov,
  output logic        ram_rw,
  output logic [1:0]  ram_size,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_moc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  stateT          state;
  stateT          nextState;
  logic           capRw;
  logic           capSigned;
  logic [1:0]     capSize;
  logic [31:0]    capAddr;
  logic [31:0]    capWdata;
  logic [CW-1:0]  waitCnt;
  logic [31:0]    alignedData;
  logic           reqBad;
  logic           timeoutHit;

  assign reqBad     = isMisaligned(cpu_size, cpu_addr[1:0]);
  // Last permitted WAIT cycle; completion in this same cycle still wins.
  assign timeoutHit = (waitCnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      S_IDLE: begin
        if (cpu_req) begin
          nextState = reqBad ? S_ERR : S_ISSUE;
        end
      end
      S_ISSUE: nextState = S_WAIT;
      S_WAIT: begin
        if (ram_moc) begin
          nextState = S_DONE;
        end else if (timeoutHit) begin
          nextState = S_ERR;
        end
      end
      S_DONE:  nextState = S_IDLE;
      S_ERR:   nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    ram_en    = 1'b0;
    ram_mov   = 1'b0;
    cpu_done  = 1'b0;
    cpu_err   = 1'b0;
    cpu_stall = 1'b0;
    unique case (state)
      S_IDLE:  cpu_stall = cpu_req & ~reset;
      S_ISSUE: begin
        ram_en    = 1'b1;
        ram_mov   = 1'b1;
        cpu_stall = 1'b1;
      end
      S_WAIT: begin
        ram_en    = 1'b1;
        cpu_stall = 1'b1;
      end
      S_DONE:  cpu_done = 1'b1;
      S_ERR: begin
        cpu_done = 1'b1;
        cpu_err  = 1'b1;
      end
      default: cpu_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      capRw     <= 1'b0;
      capSigned <= 1'b0;
      capSize   <= 2'b00;
      capAddr   <= 32'h0;
      capWdata  <= 32'h0;
      waitCnt   <= '0;
      cpu_rdata <= 32'h0;
    end else begin
      if (state == S_IDLE && cpu_req && !reqBad) begin
        capRw     <= cpu_rw;
        capSigned <= cpu_signed;
        capSize   <= cpu_size;
        capAddr   <= cpu_addr;
        case (cpu_size)
          SZ_BYTE: capWdata <= {4{cpu_wdata[7:0]}};
          SZ_HALF: capWdata <= {2{cpu_wdata[15:0]}};
          default: capWdata <= cpu_wdata;
        endcase
      end
      if (state == S_ISSUE) begin
        waitCnt <= '0;
      end else if (state == S_WAIT) begin
        waitCnt <= waitCnt + CW'(1);
      end
      if (state == S_WAIT && ram_moc && capRw) begin
        cpu_rdata <= alignedData;
      end
    end
  end

  load_align u_load_align (
    .rdata    (ram_rdata),
    .addr     (capAddr[1:0]),
    .size     (capSize),
    .isSigned (capSigned),
    .data     (alignedData)
  );

  assign ram_rw    = capRw;
  assign ram_size  = capSize;
  assign ram_addr  = capAddr;
  assign ram_wdata = capWdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed and randomized accesses against a behavioural model of the memory-stage controller.
module tb_mem_stage_ctrl;
  import mem_stage_pkg::*;

  localparam int TO = 16;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_rw;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        ram_en;
  logic        ram_mov;
  logic        ram_rw;
  logic [1:0]  ram_size;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_moc;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] expRdata = 32'h0;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_rw     (cpu_rw),
    .cpu_size   (cpu_size),
    .cpu_signed (cpu_signed),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .ram_en     (ram_en),
    .ram_mov    (ram_mov),
    .ram_rw     (ram_rw),
    .ram_size   (ram_size),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .ram_moc    (ram_moc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bytesOf(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic modelMisaligned(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'd3) || ((addr % bytesOf(sz)) != 0);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [31:0] addr,
                                            input logic [1:0] sz, input logic sgn);
    longint n   = longint'(bytesOf(sz));
    longint lim = longint'(1) << (8 * n);
    longint v;
    v = (longint'(rd) >> (8 * (addr % 4))) % lim;
    if (sgn && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  function automatic logic [31:0] modelStore(input logic [31:0] wd, input logic [1:0] sz);
    if (bytesOf(sz) == 1) return (wd & 32'hFF) * 32'h01010101;
    if (bytesOf(sz) == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  task automatic scrambleCpu();
    cpu_req    = 1'($urandom);
    cpu_rw     = 1'($urandom);
    cpu_size   = 2'($urandom);
    cpu_signed = 1'($urandom);
    cpu_addr   = $urandom;
    cpu_wdata  = $urandom;
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    cpu_req   = 1'b0;
    cpu_addr  = $urandom;
    ram_moc   = 1'($urandom);
    ram_rdata = $urandom;
    @(negedge clk);
    chk("idle_stall", cpu_stall, 1'b0);
    chk("idle_en", ram_en, 1'b0);
    chk("idle_done", cpu_done, 1'b0);
    chk("idle_rdata", cpu_rdata, expRdata);
  endtask

  // mocAt: WAIT cycle (1-based) in which the RAM completes; 0 means never.
  task automatic access(input logic rw, input logic [1:0] sz, input logic sgn, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int mocAt);
    logic bad;
    logic ok;
    bad = modelMisaligned(sz, addr);
    ok  = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_rw = rw; cpu_size = sz; cpu_signed = sgn; cpu_addr = addr; cpu_wdata = wd;
    ram_moc = 1'($urandom); ram_rdata = $urandom;
    @(negedge clk);
    chk("req_stall", cpu_stall, 1'b1);
    chk("req_en", ram_en, 1'b0);
    chk("req_done", cpu_done, 1'b0);
    @(posedge clk); #1;
    scrambleCpu();
    ram_moc = 1'($urandom); ram_rdata = $urandom;
    @(negedge clk);
    if (bad) begin
      chk("mis_done", cpu_done, 1'b1);
      chk("mis_err", cpu_err, 1'b1);
      chk("mis_stall", cpu_stall, 1'b0);
      chk("mis_en", ram_en, 1'b0);
      chk("mis_rdata", cpu_rdata, expRdata);
    end else begin
      chk("iss_en", ram_en, 1'b1);
      chk("iss_mov", ram_mov, 1'b1);
      chk("iss_stall", cpu_stall, 1'b1);
      chk("iss_rw", ram_rw, rw);
      chk("iss_size", ram_size, sz);
      chk("iss_addr", ram_addr, addr);
      chk("iss_wdata", ram_wdata, modelStore(wd, sz));
      for (int k = 1; k <= TO; k++) begin
        @(posedge clk); #1;
        scrambleCpu();
        ram_moc   = (k == mocAt);
        ram_rdata = (k == mocAt) ? rd : $urandom;
        @(negedge clk);
        chk("wait_en", ram_en, 1'b1);
        chk("wait_mov", ram_mov, 1'b0);
        chk("wait_stall", cpu_stall, 1'b1);
        chk("wait_done", cpu_done, 1'b0);
        chk("wait_addr", ram_addr, addr);
        if (k == mocAt) begin
          ok = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
      ram_moc = 1'($urandom); ram_rdata = $urandom; cpu_req = 1'($urandom);
      if (ok && rw) expRdata = modelLoad(rd, addr, sz, sgn);
      @(negedge clk);
      chk("fin_done", cpu_done, 1'b1);
      chk("fin_err", cpu_err, !ok);
      chk("fin_stall", cpu_stall, 1'b0);
      chk("fin_en", ram_en, 1'b0);
      chk("fin_rdata", cpu_rdata, expRdata);
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_stall"}, cpu_stall, 1'b0);
    chk({tag, "_done"}, cpu_done, 1'b0);
    chk({tag, "_err"}, cpu_err, 1'b0);
    chk({tag, "_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_en"}, ram_en, 1'b0);
    chk({tag, "_mov"}, ram_mov, 1'b0);
    chk({tag, "_rw"}, ram_rw, 1'b0);
    chk({tag, "_size"}, ram_size, 2'b00);
    chk({tag, "_addr"}, ram_addr, 32'h0);
    chk({tag, "_wdata"}, ram_wdata, 32'h0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_rw = 1'b0; cpu_size = 2'b00; cpu_signed = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0; ram_rdata = 32'h0; ram_moc = 1'b0;
    #1 reset = 1'b1;
    cpu_req = 1'b1;
    #1 checkAllZero("rst");
    cpu_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // Word load, RAM completes two cycles after the issue strobe.
    access(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2);
    chk("ldw_val", cpu_rdata, 32'hDEADBEEF);
    access(1'b1, SZ_BYTE, 1'b1, 32'h13, 32'h0, 32'h80112233, 1);
    chk("ldb_signed", cpu_rdata, 32'hFFFFFF80);
    access(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h0, 32'h80112233, 3);
    chk("ldb_unsigned", cpu_rdata, 32'h00000080);
    access(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0000ABCD, 32'h0, 1);
    chk("sth_keeps_rdata", cpu_rdata, 32'h00000080);
    access(1'b1, SZ_WORD, 1'b0, 32'h06, 32'h0, 32'h0, 1);
    access(1'b1, SZ_HALF, 1'b1, 32'h31, 32'h0, 32'h0, 1);
    access(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1);
    access(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h55AA55AA, 0);
    access(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0, 32'h12345678, TO);
    access(1'b1, SZ_HALF, 1'b1, 32'h2, 32'h0, 32'h9ABC1234, 1);

    // Asynchronous reset in the middle of WAIT.
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_size = SZ_WORD; cpu_addr = 32'h44; cpu_wdata = 32'hFFFFFFFF;
    ram_moc = 1'b0;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_en", ram_en, 1'b1);
    #2 reset = 1'b1;
    cpu_req = 1'b1;
    #1 checkAllZero("wait_rst");
    expRdata = 32'h0;
    cpu_req = 1'b0;
    @(negedge clk) reset = 1'b0;
    access(1'b1, SZ_HALF, 1'b0, 32'h46, 32'h0, 32'hBEEF0000, 2);

    for (int i = 0; i < 40; i++) begin
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(bytesOf(sz) - 1);
      if ($urandom_range(0, 4) == 0) idleCycle();
      access(1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom, $urandom_range(0, TO));
    end
    idleCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
